// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared state encoding and command byte defaults for ram_loader
package ram_loader_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  localparam logic [7:0] CMD_A_DEFAULT = 8'h41;
  localparam logic [7:0] CMD_W_DEFAULT = 8'h57;
  localparam logic [7:0] CMD_R_DEFAULT = 8'h52;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_READ,
    ST_READ_WAIT,
    ST_TX_HI,
    ST_TX_LO
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte-stream command loader driving a word-wide synchronous RAM
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEFAULT,
  parameter logic [7:0] CMD_A  = CMD_A_DEFAULT,
  parameter logic [7:0] CMD_W  = CMD_W_DEFAULT,
  parameter logic [7:0] CMD_R  = CMD_R_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout,
  output logic              ram_rnw,
  output logic              ram_cs_b
);

  state_t      state;
  logic [7:0]  addr_hi;
  logic [15:0] tx_buf;
  logic        rx_fire;

  // Byte intake is open only in the states that are waiting for a command or payload byte.
  always_comb begin
    rx_ready = (state == ST_IDLE)    || (state == ST_ADDR_HI) || (state == ST_ADDR_LO) ||
               (state == ST_DATA_HI) || (state == ST_DATA_LO);
    rx_fire  = rx_ready && rx_valid;
  end

  // Command FSM; RAM strobes and tx outputs are registered, set on the transition into their state.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= ST_IDLE;
      addr_hi     <= 8'h00;
      ram_address <= '0;
      ram_din     <= 16'h0000;
      tx_buf      <= 16'h0000;
      ram_cs_b    <= 1'b1;
      ram_rnw     <= 1'b1;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      // Strobes and tx_valid fall back to idle unless the next state asks for them.
      ram_cs_b <= 1'b1;
      ram_rnw  <= 1'b1;
      tx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            if (rx_data == CMD_A) begin
              state <= ST_ADDR_HI;
            end else if (rx_data == CMD_W) begin
              state <= ST_DATA_HI;
            end else if (rx_data == CMD_R) begin
              state    <= ST_READ;
              ram_cs_b <= 1'b0;
            end
          end
        end
        ST_ADDR_HI: begin
          if (rx_fire) begin
            addr_hi <= rx_data;
            state   <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (rx_fire) begin
            // Upper bits of the 16-bit address beyond the RAM depth are dropped.
            ram_address <= ADDR_W'({addr_hi, rx_data});
            state       <= ST_IDLE;
          end
        end
        ST_DATA_HI: begin
          if (rx_fire) begin
            ram_din[15:8] <= rx_data;
            state         <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (rx_fire) begin
            ram_din[7:0] <= rx_data;
            state        <= ST_WRITE;
            ram_cs_b     <= 1'b0;
            ram_rnw      <= 1'b0;
          end
        end
        ST_WRITE: begin
          ram_address <= ram_address + ADDR_W'(1);
          state       <= ST_IDLE;
        end
        ST_READ: begin
          state <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          // RAM output register is valid now, one cycle after the strobe.
          tx_buf      <= ram_dout;
          tx_data     <= ram_dout[15:8];
          tx_valid    <= 1'b1;
          ram_address <= ram_address + ADDR_W'(1);
          state       <= ST_TX_HI;
        end
        ST_TX_HI: begin
          tx_valid <= 1'b1;
          if (tx_ready) begin
            tx_data <= tx_buf[7:0];
            state   <= ST_TX_LO;
          end else begin
            tx_data <= tx_buf[15:8];
          end
        end
        ST_TX_LO: begin
          if (tx_ready) begin
            state <= ST_IDLE;
          end else begin
            tx_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard bench for ram_loader with a synchronous RAM model
module tb_ram_loader;

  typedef struct packed {
    logic        rnw;
    logic [11:0] addr;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] ram_address;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_rnw;
  logic        ram_cs_b;

  int checks = 0;
  int errors = 0;
  int tx_mode = 0;

  acc_t        acc_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] shadow [0:4095];

  always #5 clk = ~clk;

  ram_loader dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ram_address(ram_address),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_rnw    (ram_rnw),
    .ram_cs_b   (ram_cs_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic rnw, input logic [11:0] addr, input logic [15:0] data);
    acc_t a;
    a.rnw  = rnw;
    a.addr = addr;
    a.data = data;
    return a;
  endfunction

  // RAM model: registered read data, write on strobe.
  logic [15:0] mem [0:4095];
  initial begin
    ram_dout = 16'h0000;
    for (int i = 0; i < 4096; i++) mem[i] = {8'(i) ^ 8'hC3, 8'(i)};
    forever begin
      @(posedge clk);
      if (!ram_cs_b) begin
        if (ram_rnw) ram_dout <= mem[ram_address];
        else mem[ram_address] <= ram_din;
      end
    end
  end

  // Sink-side ready driver, changed just after the active edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected RAM accesses and tx bytes whenever the DUT presents them.
  initial begin
    acc_t       e;
    logic [7:0] t;
    forever begin
      @(negedge clk);
      if (reset_b && !ram_cs_b) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: rnw=%0b addr=%h din=%h expected none", ram_rnw, ram_address, ram_din);
        end else begin
          e = acc_q.pop_front();
          check("acc_rnw", 32'(ram_rnw), 32'(e.rnw));
          check("acc_addr", 32'(ram_address), 32'(e.addr));
          if (!e.rnw) check("acc_din", 32'(ram_din), 32'(e.data));
        end
      end
      if (reset_b && tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %h expected none", tx_data);
        end else begin
          t = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(t));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b, input int stall);
    int n;
    repeat (stall) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_in_time", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((acc_q.size() != 0 || tx_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 1000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_cs_b"}, 32'(ram_cs_b), 32'd1);
    check({tag, "_rnw"}, 32'(ram_rnw), 32'd1);
    check({tag, "_addr"}, 32'(ram_address), 32'h000);
    check({tag, "_din"}, 32'(ram_din), 32'h0000);
  endtask

  initial begin
    logic [11:0] a;
    logic [11:0] ra;
    logic [15:0] d;
    logic [3:0]  g;

    reset_b  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < 4096; i++) shadow[i] = {8'(i) ^ 8'hC3, 8'(i)};
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset_b = 1'b1;

    // Write 0xBEEF at 0x010.
    acc_q.push_back(mk(1'b0, 12'h010, 16'hBEEF));
    shadow[12'h010] = 16'hBEEF;
    send(8'h41, 0); send(8'h00, 0); send(8'h10, 0);
    send(8'h57, 0); send(8'hBE, 0); send(8'hEF, 0);
    wait_idle();
    check("ptr_after_write", 32'(ram_address), 32'h011);

    // Read it back.
    acc_q.push_back(mk(1'b1, 12'h010, 16'h0000));
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hEF);
    send(8'h41, 0); send(8'h00, 0); send(8'h10, 0); send(8'h52, 0);
    wait_idle();
    check("ptr_after_read", 32'(ram_address), 32'h011);

    // Pointer wrap: 0x1234 at 0xFFF, 0x5678 at 0x000.
    acc_q.push_back(mk(1'b0, 12'hFFF, 16'h1234));
    acc_q.push_back(mk(1'b0, 12'h000, 16'h5678));
    shadow[12'hFFF] = 16'h1234;
    shadow[12'h000] = 16'h5678;
    send(8'h41, 0); send(8'hFF, 0); send(8'hFF, 0);
    send(8'h57, 0); send(8'h12, 0); send(8'h34, 0);
    send(8'h57, 0); send(8'h56, 0); send(8'h78, 0);
    wait_idle();
    check("ptr_after_wrap", 32'(ram_address), 32'h001);

    // Discarded byte, then a read held off by the sink for 5 cycles.
    tx_mode = 2;
    send(8'h00, 0);
    acc_q.push_back(mk(1'b1, 12'h001, 16'h0000));
    tx_q.push_back(8'hC2);
    tx_q.push_back(8'h01);
    send(8'h52, 0);
    begin
      int n;
      n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("tx_valid_in_time", 32'(n < 50), 32'd1);
    end
    for (int c = 0; c < 5; c++) begin
      check("hold_tx_valid", 32'(tx_valid), 32'd1);
      check("hold_tx_data", 32'(tx_data), 32'hC2);
      check("hold_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
    end
    tx_mode = 0;
    wait_idle();
    check("ptr_after_held_read", 32'(ram_address), 32'h002);

    // Reset mid-command abandons the write.
    send(8'h57, 0); send(8'hAA, 0);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    check_reset_outputs("pulse");
    @(negedge clk);
    reset_b = 1'b1;
    acc_q.push_back(mk(1'b1, 12'h000, 16'h0000));
    tx_q.push_back(8'h56);
    tx_q.push_back(8'h78);
    send(8'h52, 0);
    wait_idle();
    check("ptr_after_reset_read", 32'(ram_address), 32'h001);

    // Random stalls on both streams against the shadow memory.
    tx_mode = 1;
    for (int k = 0; k < 12; k++) begin
      a = 12'($urandom);
      d = 16'($urandom);
      g = 4'($urandom);
      acc_q.push_back(mk(1'b0, a, d));
      shadow[a] = d;
      if (k % 3 == 0) send(8'h13, $urandom_range(0, 3));
      send(8'h41, $urandom_range(0, 3));
      send({g, a[11:8]}, $urandom_range(0, 3));
      send(a[7:0], $urandom_range(0, 3));
      send(8'h57, $urandom_range(0, 3));
      send(d[15:8], $urandom_range(0, 3));
      send(d[7:0], $urandom_range(0, 3));
      ra = (k % 2 == 0) ? a : 12'($urandom);
      acc_q.push_back(mk(1'b1, ra, 16'h0000));
      tx_q.push_back(shadow[ra][15:8]);
      tx_q.push_back(shadow[ra][7:0]);
      send(8'h41, $urandom_range(0, 3));
      send({4'h0, ra[11:8]}, $urandom_range(0, 3));
      send(ra[7:0], $urandom_range(0, 3));
      send(8'h52, $urandom_range(0, 3));
    end
    wait_idle();
    tx_mode = 0;
    check("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning RAM word-address width (4096 x 16 store).
REQ-002 SHALL have parameter CMD_A, default 8'h41, meaning set-pointer command byte.
REQ-003 SHALL have parameter CMD_W, default 8'h57, meaning write-word command byte.
REQ-004 SHALL have parameter CMD_R, default 8'h52, meaning read-word command byte.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single system clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- rx_data  in  8  command/payload byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte.
- tx_data  out  8  read-back byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- ram_address  out  ADDR_W  RAM word address.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, registered in RAM, valid one cycle after a read strobe.
- ram_rnw  out  1  1 = read, 0 = write.
- ram_cs_b  out  1  active-low RAM select.

Function
REQ-006 SHALL transfer a byte on a rising clk edge where valid and ready are both 1; the source holds data stable while valid=1 and ready=0.
REQ-007 SHALL implement FSM states IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WRITE, READ, READ_WAIT, TX_HI, TX_LO.
REQ-008 SHALL drive rx_ready=1 in IDLE, ADDR_HI, ADDR_LO, DATA_HI and DATA_LO, and 0 in all other states.
REQ-009 IDLE: accepted CMD_A -> ADDR_HI; CMD_W -> DATA_HI; CMD_R -> READ; any other byte is discarded, state stays IDLE.
REQ-010 ADDR_HI -> ADDR_LO on accept; ADDR_LO -> IDLE on accept; pointer = {hi,lo}[ADDR_W-1:0], upper bits ignored.
REQ-011 DATA_HI -> DATA_LO on accept; DATA_LO -> WRITE on accept; ram_din = {hi,lo}.
REQ-012 WRITE: ram_cs_b=0, ram_rnw=0, ram_address=pointer for exactly one cycle; then pointer+1, -> IDLE.
REQ-013 READ: ram_cs_b=0, ram_rnw=1 for exactly one cycle -> READ_WAIT; READ_WAIT captures ram_dout into a 16-bit tx buffer, pointer+1, -> TX_HI.
REQ-014 TX_HI: tx_valid=1, tx_data=buf[15:8] until tx_ready, -> TX_LO; TX_LO: buf[7:0], on tx_ready -> IDLE.
REQ-015 SHALL deassert tx_valid in every state other than TX_HI and TX_LO.
REQ-016 SHALL hold ram_cs_b=1 and ram_rnw=1 in every state other than WRITE and READ.
REQ-017 SHALL increment the pointer modulo 2^ADDR_W, so 12'hFFF wraps to 12'h000.
REQ-018 SHALL drive ram_address = pointer at all times, registered.
REQ-019 SHALL keep the command protocol free of timeout; a partial command waits indefinitely for its payload bytes.

Reset
REQ-020 reset_b low SHALL asynchronously force: state IDLE, pointer 0, ram_din 0, tx buffer 0, ram_cs_b=1, ram_rnw=1, tx_valid=0, tx_data=0.
REQ-021 No byte SHALL be consumed while reset_b is low; rx_ready is don't-care during reset.
REQ-022 Reset mid-command SHALL abandon the command with no RAM write, and the next accepted byte SHALL be decoded as a command.

Structure
REQ-023 State encoding and CMD_* default constants SHALL live in shared package ram_loader_pkg.
REQ-024 The block SHALL be a single FSM with no sub-module; it connects port-for-port to the 4K x 16 RAM, with ram_cs_b to cs_b and ram_rnw to rnw.

Verification
REQ-025 Byte stream 41 00 10 57 BE EF -> one cycle with cs_b=0, rnw=0, address 0x010, din 0xBEEF; pointer becomes 0x011.
REQ-026 After REQ-025, stream 41 00 10 52 with tx_ready=1 -> tx bytes BE then EF; pointer becomes 0x011.
REQ-027 Stream 41 FF FF 57 12 34 57 56 78 -> 0x1234 written at 0xFFF, 0x5678 written at 0x000 (wrap).
REQ-028 Byte 0x00 then 52 with tx_ready held 0 for 5 cycles -> 0x00 discarded, no RAM access; tx_valid=1 held with tx_data stable for 5 cycles, rx_ready=0 throughout.
REQ-029 Stream 57 AA, then reset_b pulsed low, then 52 -> no write occurs; read strobe at address 0x000; all outputs at reset values during the pulse.
REQ-030 Bench SHALL run random rx_valid/tx_ready stalls against a RAM model and check all read-back bytes against a scoreboard.
